axi4_stream_pkt_arbiter: RTL and testbench
==========================================

// Module: axi4_stream_pkt_arbiter
// PURPOSE
// Packet-granular round-robin arbiter sharing one AXI4-Stream datapath (e.g. an
// upsizer/downsizer input) between INPUTS requesters. A grant is locked from the
// first beat until the tlast handshake, so packets never interleave. Sits directly
// upstream of the shared width converter.
// PARAMETERS
// INPUTS         4   number of requesting streams, >= 2
// TDATA_WIDTH    16  tdata width of all ports, multiple of 8
// TID_WIDTH      2   tid width; must be >= $clog2(INPUTS) when TID_FROM_PORT=1
// TDEST_WIDTH    1   tdest width
// TUSER_WIDTH    1   tuser width
// TID_FROM_PORT  0   1: pkt_o.tid = granted port index; 0: pass-through tid
// PORTS
// clk_i     in   1            clock, all logic on rising edge
// rst_n_i   in   1            reset, asynchronous, active-low
// pkt_i     slv  [INPUTS]     axi4_stream_if.slave array, one per requester
// pkt_o     mst  1            axi4_stream_if.master to the shared datapath
// grant_o   out  INPUTS       one-hot current grant, 0 when IDLE
// busy_o    out  1            1 while state == BUSY
// BEHAVIOUR
// - Reset (rst_n_i=0, async): state=IDLE, grant=0, rr pointer=0; pkt_o.tvalid=0,
//   all pkt_i[k].tready=0, grant_o=0, busy_o=0; pkt_o payload don't-care (drive 0).
// - FSM: IDLE, BUSY. Grant index and pointer are registers; no comb path from any
//   pkt_i.tvalid to pkt_o.tvalid in IDLE.
// - IDLE: if any pkt_i[k].tvalid, pick winner w = first set bit scanning from
//   pointer upward with wrap (INPUTS-1 -> 0); next cycle: BUSY, grant=w. No
//   requests -> stay IDLE. One-cycle arbitration latency from IDLE.
// - BUSY: pkt_o mirrors pkt_i[grant] (tvalid,tdata,tkeep,tstrb,tlast,tdest,tuser;
//   tid per TID_FROM_PORT); pkt_i[grant].tready = pkt_o.tready; all other
//   tready = 0. Pure combinational mux: zero added latency per beat.
// - Packet end: on pkt_o tvalid&&tready&&tlast, pointer <= grant+1 (mod INPUTS).
//   Same cycle, pick next winner from tvalid of all inputs EXCEPT current grant,
//   scanning from grant+1: found -> stay BUSY with new grant (back-to-back, no
//   bubble); none -> IDLE. Current input re-competes only via IDLE next cycle.
// - Non-tlast handshakes and pkt_o.tready=0 never change grant or pointer.
// - Granted input dropping tvalid mid-packet: grant held, pkt_o.tvalid follows
//   it (bubble passes through); no timeout.
// - Single-beat packets (tvalid&&tlast on first beat) are legal; 1 beat in BUSY.
// - INPUTS not a power of two: pointer wrap uses explicit compare, not overflow.
// - Reset mid-packet: grant dropped immediately; partial packet is upstream's
//   problem, arbiter restarts in IDLE with pointer 0.
// STRUCTURE
// - axi4_stream_arb_pkg: typedef enum logic {IDLE, BUSY} arb_state_t;
//   function rr_pick(req, ptr) returning {found, index}.
// - Sub-module rr_picker #(INPUTS): combinational masked round-robin select
//   (req, mask, ptr -> valid, idx); instantiated once, mask = ~grant at packet end.
// - Top holds FSM, grant/pointer regs, generate-loop mux over interface array.
// TESTING
// - Reset: hold rst_n_i=0, drive all tvalid=1 -> all tready=0, pkt_o.tvalid=0,
//   grant_o=0; release -> grant_o=4'b0001 one cycle after first clock.
// - Fairness: all 4 inputs send endless 3-beat packets, tready=1 -> grant
//   sequence 0,1,2,3,0,... with no idle cycles between packets, 12 beats/12 clk.
// - No interleave: in0 8-beat packet, in2 raises tvalid on beat 2 -> in2 tready
//   stays 0 until in0 tlast accepted; in2 granted next cycle, no bubble.
// - Backpressure: pkt_o.tready random 50%, in1 only requester, 5-beat packet
//   -> data order intact, grant fixed at 1, returns IDLE after tlast.
// - Sole requester repeats: in3 only, two 1-beat packets -> BUSY, IDLE, BUSY
//   (one-cycle bubble between them); pointer = 0 after each.
// - TID_FROM_PORT=1, INPUTS=3, TID_WIDTH=2: packet from in2 -> pkt_o.tid=2'd2;
//   pointer wraps 2 -> 0.

Source files
------------

// File: rtl/axi4_stream_arb_pkg.sv
// Shared types and the round-robin search used by the packet arbiter.
// rr_pick scans upward from ptr with wrap and returns the first set request.
package axi4_stream_arb_pkg;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

   localparam int RR_MAX_INPUTS = 32;
   localparam int RR_IDX_W      = 5;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] index;
   } rr_pick_t;

   function automatic rr_pick_t rr_pick(input logic [RR_MAX_INPUTS-1:0] req,
                                        input logic [RR_IDX_W-1:0]      ptr,
                                        input int unsigned              n);
      rr_pick_t    res;
      int unsigned j;
      res = '0;
      for (int unsigned i = 0; i < RR_MAX_INPUTS; i++) begin
         if (i < n) begin
            // explicit wrap so non-power-of-two port counts stay in range
            j = 32'(ptr) + i;
            if (j >= n) j = j - n;
            if (!res.found && req[j]) begin
               res.found = 1'b1;
               res.index = RR_IDX_W'(j);
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream interface with master and slave views.
interface axi4_stream_if #(
   parameter int TDATA_WIDTH = 16,
   parameter int TID_WIDTH   = 2,
   parameter int TDEST_WIDTH = 1,
   parameter int TUSER_WIDTH = 1
) ();
   logic                       tvalid;
   logic                       tready;
   logic [TDATA_WIDTH-1:0]     tdata;
   logic [TDATA_WIDTH/8-1:0]   tkeep;
   logic [TDATA_WIDTH/8-1:0]   tstrb;
   logic                       tlast;
   logic [TID_WIDTH-1:0]       tid;
   logic [TDEST_WIDTH-1:0]     tdest;
   logic [TUSER_WIDTH-1:0]     tuser;

   modport master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                   input  tready);
   modport slave  (input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                   output tready);
endinterface

// File: rtl/axi4_stream_pkt_arbiter_rr_picker.sv
// Combinational masked round-robin select: first req&mask bit at or above ptr.
module rr_picker
   import axi4_stream_arb_pkg::*;
#(
   parameter int INPUTS = 4,
   parameter int IDX_W  = $clog2(INPUTS)
) (
   input  logic [INPUTS-1:0] req_i,
   input  logic [INPUTS-1:0] mask_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic              valid_o,
   output logic [IDX_W-1:0]  idx_o
);
   rr_pick_t                 pick;
   logic [RR_MAX_INPUTS-1:0] req_ext;

   always_comb begin
      req_ext             = '0;
      req_ext[INPUTS-1:0] = req_i & mask_i;
      pick                = rr_pick(req_ext, RR_IDX_W'(ptr_i), INPUTS);
      valid_o             = pick.found;
      idx_o               = IDX_W'(pick.index);
   end
endmodule

// File: rtl/axi4_stream_pkt_arbiter.sv
// Packet-granular round-robin arbiter: grant is locked from first beat to the
// tlast handshake, and the next winner is chosen in that same cycle.
module axi4_stream_pkt_arbiter
   import axi4_stream_arb_pkg::*;
#(
   parameter int INPUTS        = 4,
   parameter int TDATA_WIDTH   = 16,
   parameter int TID_WIDTH     = 2,
   parameter int TDEST_WIDTH   = 1,
   parameter int TUSER_WIDTH   = 1,
   parameter bit TID_FROM_PORT = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   axi4_stream_if.slave      pkt_i [INPUTS],
   axi4_stream_if.master     pkt_o,
   output logic [INPUTS-1:0] grant_o,
   output logic              busy_o
);
   localparam int              IDX_W    = $clog2(INPUTS);
   localparam int              KEEP_W   = TDATA_WIDTH / 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUTS - 1);

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d, ptr_q, ptr_d;
   logic [IDX_W-1:0]  next_ptr, pick_ptr, pick_idx;
   logic [INPUTS-1:0] req, in_tlast, grant_oh, pick_mask;
   logic              pick_valid, pkt_end;
   logic [TID_WIDTH-1:0] sel_tid;

   logic [TDATA_WIDTH-1:0] in_tdata [INPUTS];
   logic [KEEP_W-1:0]      in_tkeep [INPUTS];
   logic [KEEP_W-1:0]      in_tstrb [INPUTS];
   logic [TDEST_WIDTH-1:0] in_tdest [INPUTS];
   logic [TUSER_WIDTH-1:0] in_tuser [INPUTS];

   for (genvar k = 0; k < INPUTS; k++) begin : g_port
      assign req[k]         = pkt_i[k].tvalid;
      assign in_tlast[k]    = pkt_i[k].tlast;
      assign in_tdata[k]    = pkt_i[k].tdata;
      assign in_tkeep[k]    = pkt_i[k].tkeep;
      assign in_tstrb[k]    = pkt_i[k].tstrb;
      assign in_tdest[k]    = pkt_i[k].tdest;
      assign in_tuser[k]    = pkt_i[k].tuser;
      assign pkt_i[k].tready = grant_oh[k] & pkt_o.tready;
   end

   if (TID_FROM_PORT) begin : g_tid_port
      assign sel_tid = TID_WIDTH'(grant_q);
   end else begin : g_tid_pass
      logic [TID_WIDTH-1:0] in_tid [INPUTS];
      for (genvar k = 0; k < INPUTS; k++) begin : g_tid
         assign in_tid[k] = pkt_i[k].tid;
      end
      assign sel_tid = in_tid[grant_q];
   end

   always_comb begin
      grant_oh = '0;
      if (state_q == BUSY) grant_oh[grant_q] = 1'b1;
   end

   assign next_ptr  = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
   assign pkt_end   = (state_q == BUSY) && req[grant_q] && in_tlast[grant_q] && pkt_o.tready;
   // at packet end the finishing port is masked out and the scan starts after it
   assign pick_mask = (state_q == BUSY) ? ~grant_oh : '1;
   assign pick_ptr  = (state_q == BUSY) ? next_ptr : ptr_q;

   rr_picker #(.INPUTS(INPUTS), .IDX_W(IDX_W)) u_picker (
      .req_i   (req),
      .mask_i  (pick_mask),
      .ptr_i   (pick_ptr),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = BUSY;
               grant_d = pick_idx;
            end
         end
         BUSY: begin
            if (pkt_end) begin
               ptr_d = next_ptr;
               if (pick_valid) grant_d = pick_idx;
               else            state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      pkt_o.tvalid = 1'b0;
      pkt_o.tdata  = '0;
      pkt_o.tkeep  = '0;
      pkt_o.tstrb  = '0;
      pkt_o.tlast  = 1'b0;
      pkt_o.tid    = '0;
      pkt_o.tdest  = '0;
      pkt_o.tuser  = '0;
      if (state_q == BUSY) begin
         pkt_o.tvalid = req[grant_q];
         pkt_o.tdata  = in_tdata[grant_q];
         pkt_o.tkeep  = in_tkeep[grant_q];
         pkt_o.tstrb  = in_tstrb[grant_q];
         pkt_o.tlast  = in_tlast[grant_q];
         pkt_o.tid    = sel_tid;
         pkt_o.tdest  = in_tdest[grant_q];
         pkt_o.tuser  = in_tuser[grant_q];
      end
   end

   assign grant_o = grant_oh;
   assign busy_o  = (state_q == BUSY);

endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Bench for axi4_stream_pkt_arbiter: directed scenarios plus randomized packet
// traffic compared against a packet-order reference model.
module tb_axi4_stream_pkt_arbiter;
   localparam int N = 4;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  keep;
      logic        last;
      logic [1:0]  tid;
      logic        dest;
      logic        user;
   } beat_t;

   typedef struct {
      int    port;
      beat_t b;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // main DUT: 4 inputs, tid pass-through
   axi4_stream_if #(.TDATA_WIDTH(16), .TID_WIDTH(2), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) a_in [N] ();
   axi4_stream_if #(.TDATA_WIDTH(16), .TID_WIDTH(2), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) a_out ();
   logic [N-1:0] a_grant;
   logic         a_busy;
   logic [N-1:0] src_vld;
   logic [N-1:0] src_rdy;
   beat_t        src_beat [N];
   logic         a_rdy;

   axi4_stream_pkt_arbiter #(
      .INPUTS(4), .TDATA_WIDTH(16), .TID_WIDTH(2), .TDEST_WIDTH(1), .TUSER_WIDTH(1),
      .TID_FROM_PORT(1'b0)
   ) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .pkt_i(a_in), .pkt_o(a_out),
      .grant_o(a_grant), .busy_o(a_busy)
   );

   for (genvar k = 0; k < N; k++) begin : g_a
      assign a_in[k].tvalid = src_vld[k];
      assign a_in[k].tdata  = src_beat[k].data;
      assign a_in[k].tkeep  = src_beat[k].keep;
      assign a_in[k].tstrb  = src_beat[k].keep;
      assign a_in[k].tlast  = src_beat[k].last;
      assign a_in[k].tid    = src_beat[k].tid;
      assign a_in[k].tdest  = src_beat[k].dest;
      assign a_in[k].tuser  = src_beat[k].user;
      assign src_rdy[k]     = a_in[k].tready;
   end
   assign a_out.tready = a_rdy;

   // second DUT: 3 inputs, tid taken from port index
   axi4_stream_if #(.TDATA_WIDTH(16), .TID_WIDTH(2), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) b_in [3] ();
   axi4_stream_if #(.TDATA_WIDTH(16), .TID_WIDTH(2), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) b_out ();
   logic [2:0]  b_grant;
   logic        b_busy;
   logic [2:0]  b_vld;
   logic [2:0]  b_rdy;
   logic [1:0]  b_tid [3];

   axi4_stream_pkt_arbiter #(
      .INPUTS(3), .TDATA_WIDTH(16), .TID_WIDTH(2), .TDEST_WIDTH(1), .TUSER_WIDTH(1),
      .TID_FROM_PORT(1'b1)
   ) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .pkt_i(b_in), .pkt_o(b_out),
      .grant_o(b_grant), .busy_o(b_busy)
   );

   for (genvar k = 0; k < 3; k++) begin : g_b
      assign b_in[k].tvalid = b_vld[k];
      assign b_in[k].tdata  = 16'(16'h00B0 + k);
      assign b_in[k].tkeep  = 2'b11;
      assign b_in[k].tstrb  = 2'b11;
      assign b_in[k].tlast  = 1'b1;
      assign b_in[k].tid    = b_tid[k];
      assign b_in[k].tdest  = 1'b0;
      assign b_in[k].tuser  = 1'b0;
      assign b_rdy[k]       = b_in[k].tready;
   end
   assign b_out.tready = 1'b1;

   int    vectors     = 0;
   int    miscompares = 0;
   beat_t src_q [N][$];
   int    pkt_len_q [N][$];
   exp_t  exp_q [$];
   int    ptr_model = 0;
   int    hold_beats [N];
   bit    mid_pkt [N];
   bit    gaps_en = 1'b0;
   int    rdy_pct = 100;
   int    first_hs, last_hs, out_count;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int p);
      logic [N-1:0] v;
      v    = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   task automatic add_packet(input int port, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = 16'($urandom);
         b.keep = 2'($urandom);
         b.last = (i == len - 1);
         b.tid  = 2'($urandom);
         b.dest = 1'($urandom);
         b.user = 1'($urandom);
         src_q[port].push_back(b);
      end
      pkt_len_q[port].push_back(len);
   endtask

   // Packet order: after a packet on port g (or from the pointer at start),
   // the next packet comes from the first port after g, wrapping, that still
   // has packets; g itself is the last candidate.
   task automatic build_expect();
      int pos [N];
      int pk [N];
      int p, len, c;
      for (int k = 0; k < N; k++) begin
         pos[k] = 0;
         pk[k]  = 0;
      end
      while (1'b1) begin
         p = -1;
         for (int i = 0; i < N; i++) begin
            c = (ptr_model + i) % N;
            if (p < 0 && pk[c] < pkt_len_q[c].size()) p = c;
         end
         if (p < 0) break;
         len = pkt_len_q[p][pk[p]];
         for (int j = 0; j < len; j++) begin
            exp_t e;
            e.port = p;
            e.b    = src_q[p][pos[p] + j];
            exp_q.push_back(e);
         end
         pos[p]    += len;
         pk[p]     += 1;
         ptr_model  = (p + 1) % N;
      end
      for (int k = 0; k < N; k++) pkt_len_q[k].delete();
   endtask

   // Starts and ends at a falling clock edge.
   task automatic run_traffic(input string name, input int max_cycles);
      int cyc;
      exp_t e;
      cyc       = 0;
      first_hs  = -1;
      last_hs   = -1;
      out_count = 0;
      for (int k = 0; k < N; k++) mid_pkt[k] = 1'b0;
      build_expect();
      while (exp_q.size() > 0 && cyc < max_cycles) begin
         for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0 && out_count >= hold_beats[k] &&
                !(gaps_en && mid_pkt[k] && $urandom_range(0, 3) == 0)) begin
               src_vld[k]  = 1'b1;
               src_beat[k] = src_q[k][0];
            end else begin
               src_vld[k]  = 1'b0;
               src_beat[k] = '0;
            end
         end
         a_rdy = ($urandom_range(0, 99) < rdy_pct);
         #4;
         check({name, " tready"}, 64'(src_rdy), 64'(a_grant & {N{a_rdy}}));
         if (a_out.tvalid && a_rdy) begin
            e = exp_q.pop_front();
            check({name, " beat"},
                  {a_grant, a_out.tdata, a_out.tkeep, a_out.tstrb, a_out.tlast,
                   a_out.tid, a_out.tdest, a_out.tuser},
                  {onehot(e.port), e.b.data, e.b.keep, e.b.keep, e.b.last,
                   e.b.tid, e.b.dest, e.b.user});
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            out_count++;
         end
         for (int k = 0; k < N; k++) begin
            if (src_vld[k] && src_rdy[k]) begin
               mid_pkt[k] = !src_q[k][0].last;
               src_q[k].delete(0);
            end
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      src_vld = '0;
      a_rdy   = 1'b0;
      for (int k = 0; k < N; k++) src_beat[k] = '0;
      check({name, " completed in budget"}, 64'(exp_q.size()), 64'd0);
      check({name, " idle after"}, {a_busy, a_grant}, '0);
      exp_q.delete();
      for (int k = 0; k < N; k++) begin
         src_q[k].delete();
         hold_beats[k] = 0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset with every input requesting
      rst_n   = 1'b0;
      a_rdy   = 1'b0;
      src_vld = '1;
      b_vld   = '0;
      for (int k = 0; k < N; k++) begin
         src_beat[k] = '{data: 16'hA000 + 16'(k), keep: 2'b11, last: 1'b0, tid: 2'd0, dest: 1'b0, user: 1'b0};
         hold_beats[k] = 0;
      end
      for (int k = 0; k < 3; k++) b_tid[k] = 2'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst tready", 64'(src_rdy), 64'd0);
      check("rst out tvalid", 64'(a_out.tvalid), 64'd0);
      check("rst grant", 64'(a_grant), 64'd0);
      check("rst busy", 64'(a_busy), 64'd0);
      check("rst payload", 64'(a_out.tdata), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("release grant", 64'(a_grant), 64'b0001);
      check("release busy", 64'(a_busy), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async rst grant", 64'(a_grant), 64'd0);
      check("async rst tvalid", 64'(a_out.tvalid), 64'd0);
      src_vld = '0;
      for (int k = 0; k < N; k++) src_beat[k] = '0;
      @(negedge clk);
      rst_n     = 1'b1;
      ptr_model = 0;
      @(negedge clk);

      // tid from port index, pointer wrap on a 3-input arbiter
      b_vld[2] = 1'b1;
      b_tid[2] = 2'd1;
      @(posedge clk);
      #1;
      check("tid3 grant in2", 64'(b_grant), 64'b100);
      check("tid3 tid in2", 64'(b_out.tid), 64'd2);
      check("tid3 tready in2", 64'(b_rdy), 64'b100);
      @(posedge clk);
      #1;
      check("tid3 idle after in2", 64'(b_busy), 64'd0);
      b_vld = 3'b011;
      @(posedge clk);
      #1;
      check("tid3 wrap grant in0", 64'(b_grant), 64'b001);
      check("tid3 tid in0", 64'(b_out.tid), 64'd0);
      @(posedge clk);
      #1;
      b_vld[0] = 1'b0;
      check("tid3 b2b grant in1", 64'(b_grant), 64'b010);
      check("tid3 tid in1", 64'(b_out.tid), 64'd1);
      @(posedge clk);
      #1;
      b_vld = '0;
      check("tid3 idle end", 64'(b_busy), 64'd0);
      @(negedge clk);

      // no interleave: in2 appears during in0's 8-beat packet
      rdy_pct = 100;
      gaps_en = 1'b0;
      add_packet(0, 8);
      add_packet(2, 3);
      hold_beats[2] = 2;
      run_traffic("nointerleave", 200);
      check("nointerleave span", 64'(last_hs - first_hs + 1), 64'd11);

      // sole requester repeats through IDLE
      add_packet(3, 1);
      add_packet(3, 1);
      run_traffic("sole", 100);
      check("sole span", 64'(last_hs - first_hs + 1), 64'd3);

      // fairness with all inputs loaded and no backpressure
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < N; k++) add_packet(k, 3);
      run_traffic("fair", 300);
      check("fair span", 64'(last_hs - first_hs + 1), 64'd36);

      // backpressure on a single 5-beat packet
      rdy_pct = 50;
      add_packet(1, 5);
      run_traffic("backpressure", 300);

      // randomized traffic with backpressure and mid-packet gaps
      gaps_en = 1'b1;
      for (int r = 0; r < 8; r++) begin
         rdy_pct = $urandom_range(30, 100);
         for (int k = 0; k < N; k++) begin
            int npk;
            npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) add_packet(k, $urandom_range(1, 6));
         end
         run_traffic("random", 2000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
